// File: rtl/sosanh_search.sv
// Successive-approximation search controller: drives a magnitude comparator's B operand
// with a registered guess and binary-searches the unknown A operand from its X/Y/Z flags.
module sosanh_search #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             X,
  input  logic             Y,
  input  logic             Z,
  output logic [WIDTH-1:0] guess,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probes,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V   = '1;
  localparam logic [WIDTH-1:0] FIRST_G = MAX_V >> 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] probes_q, probes_d;
  logic             busy_q, done_q, err_q;

  // Midpoints are formed one bit wider so the sum never truncates before the shift.
  logic [WIDTH:0] sum_up, sum_dn;
  logic [WIDTH-1:0] guess_inc, guess_dec;

  assign guess_inc = guess_q + WIDTH'(1);
  assign guess_dec = guess_q - WIDTH'(1);
  assign sum_up    = {1'b0, guess_inc} + {1'b0, hi_q};
  assign sum_dn    = {1'b0, lo_q} + {1'b0, guess_dec};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    probes_d = probes_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MAX_V;
          guess_d  = FIRST_G;
          probes_d = CNT_W'(1);
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        // Anything other than exactly one flag is a malformed comparator response.
        unique case ({X, Y, Z})
          3'b010: begin
            result_d = guess_q;
            state_d  = S_DONE;
          end
          3'b100: begin
            if (guess_q == hi_q) begin
              state_d = S_ERR;
            end else begin
              lo_d     = guess_inc;
              guess_d  = sum_up[WIDTH:1];
              probes_d = probes_q + CNT_W'(1);
            end
          end
          3'b001: begin
            if (guess_q == lo_q) begin
              state_d = S_ERR;
            end else begin
              hi_d     = guess_dec;
              guess_d  = sum_dn[WIDTH:1];
              probes_d = probes_q + CNT_W'(1);
            end
          end
          default: state_d = S_ERR;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= MAX_V;
      guess_q  <= '0;
      result_q <= '0;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      probes_q <= probes_d;
      busy_q   <= (state_d == S_EVAL);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign probes = probes_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sosanh_search.sv
// Directed bench for sosanh_search: a behavioural comparator answers each guess,
// with overrides for forced flags and an inconsistent always-greater comparator.
module tb_sosanh_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       X, Y, Z;
  logic [3:0] guess, result;
  logic [2:0] probes;
  logic       busy, done, err;

  logic [3:0] a_val;
  logic       always_x;
  logic       force_en;
  logic [2:0] force_xyz;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sosanh_search #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .Z(Z),
    .guess(guess), .result(result), .probes(probes),
    .busy(busy), .done(done), .err(err)
  );

  always_comb begin
    X = 1'b0; Y = 1'b0; Z = 1'b0;
    if (force_en) begin
      {X, Y, Z} = force_xyz;
    end else if (always_x) begin
      X = 1'b1;
    end else begin
      X = (a_val > guess);
      Y = (a_val == guess);
      Z = (a_val < guess);
    end
  end

  typedef struct {
    string            name;
    logic [3:0]       a;
    logic             ax;
    int               n;
    logic [0:4][3:0]  seq;
    logic             exp_err;
    logic [2:0]       exp_probes;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && probes > 3'd5) begin
      tests++;
      failed++;
      $display("FAIL probe_bound: got %0d expected <= 5", probes);
    end
  end

  task automatic run_vec(input vec_t v, input bit poke_start);
    a_val    = v.a;
    always_x = v.ax;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      chk({v.name, "_busy"}, busy, 1);
      chk({v.name, "_done_low"}, done, 0);
      chk({v.name, "_err_low"}, err, 0);
      chk($sformatf("%s_guess%0d", v.name, i), guess, v.seq[i]);
      if (poke_start && i == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk({v.name, "_busy_end"}, busy, 0);
    chk({v.name, "_done"}, done, !v.exp_err);
    chk({v.name, "_err"}, err, v.exp_err);
    chk({v.name, "_probes"}, probes, v.exp_probes);
    if (!v.exp_err) chk({v.name, "_result"}, result, v.a);
    else chk({v.name, "_guess_hold"}, guess, v.seq[v.n-1]);
  endtask

  initial begin
    vecs[0] = '{"a7",  4'd7,  1'b0, 1, {4'd7, 4'd0, 4'd0, 4'd0, 4'd0},   1'b0, 3'd1};
    vecs[1] = '{"a15", 4'd15, 1'b0, 5, {4'd7, 4'd11, 4'd13, 4'd14, 4'd15}, 1'b0, 3'd5};
    vecs[2] = '{"a0",  4'd0,  1'b0, 4, {4'd7, 4'd3, 4'd1, 4'd0, 4'd0},   1'b0, 3'd4};
    vecs[3] = '{"a9",  4'd9,  1'b0, 3, {4'd7, 4'd11, 4'd9, 4'd0, 4'd0},  1'b0, 3'd3};
    vecs[4] = '{"a5",  4'd5,  1'b0, 3, {4'd7, 4'd3, 4'd5, 4'd0, 4'd0},   1'b0, 3'd3};
    vecs[5] = '{"a10", 4'd10, 1'b0, 4, {4'd7, 4'd11, 4'd9, 4'd10, 4'd0}, 1'b0, 3'd4};
    vecs[6] = '{"allx", 4'd0, 1'b1, 5, {4'd7, 4'd11, 4'd13, 4'd14, 4'd15}, 1'b1, 3'd5};

    rst = 1'b1; start = 1'b0; a_val = 4'd0; always_x = 1'b0;
    force_en = 1'b0; force_xyz = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_guess", guess, 0);
    chk("rst_result", result, 0);
    chk("rst_probes", probes, 0);
    chk("rst_flags", {busy, done, err}, 0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], 1'b0);

    // Malformed flags on the first probe, then a clean rerun clears err.
    force_en = 1'b1; force_xyz = 3'b110;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("force_busy", busy, 1);
    @(negedge clk);
    chk("force_err", err, 1);
    chk("force_done", done, 0);
    force_en = 1'b0;
    run_vec(vecs[3], 1'b0);

    // Zero flags is also malformed.
    force_en = 1'b1; force_xyz = 3'b000;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    chk("noflag_err", err, 1);
    force_en = 1'b0;

    // Reset in the third EVAL cycle aborts with no residue.
    a_val = 4'd15; always_x = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_guess", guess, 13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_guess", guess, 0);
    chk("midrst_result", result, 0);
    chk("midrst_probes", probes, 0);
    chk("midrst_flags", {busy, done, err}, 0);
    @(negedge clk);
    chk("midrst_idle", {busy, done, err}, 0);

    // Start pulsed mid-search is ignored.
    run_vec(vecs[1], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sosanh_search.md
Name: sosanh_search

Overview:
- Successive-approximation search controller: the initiator side of the team's magnitude comparator (sosanhC2 flag convention).
- Drives the comparator's B operand with a registered guess and consumes its X/Y/Z relation flags.
- Binary-searches until the unknown value on the comparator's A operand is found; reports the value and probe count.
- Sits between a comparator instance and control logic needing to recover an operand it cannot read directly.

Parameters:
- WIDTH, 4, width of the searched value and of guess/result.
- CNT_W, 3, width of probe counter; must hold WIDTH+1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a search; sampled in IDLE, DONE, ERR; ignored while busy.
- X  input  1  comparator flag: A > guess.
- Y  input  1  comparator flag: A == guess.
- Z  input  1  comparator flag: A < guess.
- guess  output  WIDTH  registered probe value, drives comparator B.
- result  output  WIDTH  found value, valid while done=1.
- probes  output  CNT_W  number of probes used in the current/last search.
- busy  output  1  high in EVAL.
- done  output  1  high in DONE (level, held until next start).
- err  output  1  high in ERR (level, held until next start).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: state=IDLE; guess=0, result=0, probes=0, busy=0, done=0, err=0; lo=0, hi=all ones. Reset mid-search aborts immediately; no residual done/err.
- States: IDLE, EVAL, DONE, ERR. busy=(EVAL), done=(DONE), err=(ERR), all registered.
- IDLE/DONE/ERR with start=1: lo<=0, hi<=2^WIDTH-1, guess<=(lo+hi)>>1 (=7 for WIDTH=4), probes<=1, done/err cleared, state<=EVAL.
- Comparator is combinational; flags for the registered guess are valid in the same cycle. One probe per EVAL cycle.
- EVAL, exactly one flag set:
  - Y: result<=guess, state<=DONE, probes unchanged.
  - X and guess==hi: state<=ERR.
  - X otherwise: lo<=guess+1, guess<=(guess+1+hi)>>1, probes<=probes+1.
  - Z and guess==lo: state<=ERR.
  - Z otherwise: hi<=guess-1, guess<=(lo+guess-1)>>1, probes<=probes+1.
- EVAL, zero flags or more than one flag set: state<=ERR (malformed comparator output).
- Arithmetic: midpoint sum computed at WIDTH+1 bits, then shifted; no truncation before shift. lo/hi never wrap, because the guess==lo/hi checks precede any ±1.
- Probe bound: at most WIDTH+1 probes (5 for WIDTH=4). A probes count above WIDTH+1 is a design error; the bench asserts it never occurs.
- start while in EVAL: ignored, no effect.
- guess holds its last value in DONE/ERR; result holds until the next Y.

Test Plan:
- Reset, then A=7 comparator model, start pulse -> EVAL 1 cycle with guess=7; next cycle done=1, result=7, probes=1, busy=0.
- A=15 -> guess sequence 7,11,13,14,15 on consecutive cycles; done=1, result=15, probes=5.
- A=0 -> guess sequence 7,3,1,0; done=1, result=0, probes=4; a second start with A=9 -> guesses 7,11,9, result=9, probes=3, done dropped the cycle after start.
- Forced flags X=1,Y=1 in the first EVAL cycle -> err=1 next cycle, done=0; start then clears err, and search reruns normally.
- Inconsistent model always returning X -> guesses 7,11,13,14,15, then err=1 (X at guess==hi), probes=5, no wrap to 0.
- rst asserted during the third EVAL cycle -> next cycle all outputs 0, state IDLE; start pulse during EVAL (no rst) -> ignored, sequence unchanged.
